// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, frame bit positions and common scancodes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam int unsigned START_BIT    = 0;
    localparam int unsigned DATA_LSB_BIT = 1;
    localparam int unsigned DATA_MSB_BIT = 8;
    localparam int unsigned PARITY_BIT   = 9;
    localparam int unsigned STOP_BIT     = 10;
    localparam int unsigned FRAME_BITS   = STOP_BIT + 1;
    localparam int unsigned DATA_BITS    = DATA_MSB_BIT - DATA_LSB_BIT + 1;

    localparam logic [7:0] KEY_RELEASE = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer plus saturating glitch filter for one PS/2 line.
// level_o resets to 1; fall_o pulses in the cycle level_o first reads 0.
module ps2_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive synchronized samples that disagree with the filtered level.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: filters the pins, deserializes and checks frames, buffers scancodes.
// Define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overflow_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic clk_fall, data_lvl, clk_lvl_unused, data_fall_unused;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl_unused),
        .fall_o  (clk_fall)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    ps2_rx_state_t    state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic             commit_c;

    // Frame FSM: advances on filtered clock falls only, except for the inter-edge timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        tmo_d     = (state_q == IDLE) ? '0 : tmo_q + TMO_W'(1);
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        commit_c  = 1'b0;
        if (clk_fall) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!data_lvl) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d[bit_cnt_q] = data_lvl;
                    bit_cnt_d          = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, data_lvl};
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_lvl)      ferr_d   = 1'b1;
                    else if (!par_ok_q) perr_d   = 1'b1;
                    else                commit_c = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overflow_o   = ovf_q;

`ifdef PS2_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          empty_c, full_c, pop_c, push_c;

    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_c   = !empty_c && ready_i;
    // A pop frees the slot the write lands in, so full-with-pop still accepts the byte.
    assign push_c  = commit_c && (!full_c || pop_c);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = commit_c && !push_c;
        if (pop_c)  rptr_d = rptr_q + PW'(1);
        if (push_c) wptr_d = wptr_q + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_c) mem_q[wptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign valid_o = !empty_c;
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       pop_c;
    logic       unused_depth;

    assign unused_depth = ^FIFO_DEPTH;
    assign pop_c        = valid_q && ready_i;

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q && !pop_c;
        ovf_d   = 1'b0;
        if (commit_c) begin
            if (!valid_q || pop_c) begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = hold_q;
    assign valid_o = valid_q;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of single frames plus overflow, timeout, glitch and reset sequences.
`timescale 1ns/1ps
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 10000;
    localparam int HALF = 40;
`ifdef PS2_RX_FIFO_EN
    localparam int EXP_HELD = 3;
    localparam int EXP_OVF  = 0;
`else
    localparam int EXP_HELD = 1;
    localparam int EXP_OVF  = 2;
`endif

    logic       clk_i = 1'b0, reset_ni = 1'b0, ps2_clk_i = 1'b1, ps2_data_i = 1'b1, ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, parity_err_o, frame_err_o, overflow_o;

    always #5 clk_i = ~clk_i;

    ps2_rx dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .parity_err_o(parity_err_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o)
    );

    // Event log sampled on the falling clock edge.
    int         n_rx = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
    logic [7:0] rx_log [256];
    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (valid_o && ready_i) begin
                rx_log[n_rx[7:0]] <= data_o;
                n_rx <= n_rx + 1;
            end
            if (parity_err_o) n_perr <= n_perr + 1;
            if (frame_err_o)  n_ferr <= n_ferr + 1;
            if (overflow_o)   n_ovf  <= n_ovf + 1;
        end
    end

    int n_chk = 0, n_pass = 0;
    int last_lat;
    int b_rx, b_perr, b_ferr, b_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic snap();
        b_rx = n_rx; b_perr = n_perr; b_ferr = n_ferr; b_ovf = n_ovf;
    endtask

    // Drives the first nbits bits of a frame; last_lat = cycles from a raw fall to valid_o.
    task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop_bit,
                              input int nbits, input logic glitch);
        logic [10:0] fr;
        fr = {stop_bit, (~^code) ^ par_flip, code, 1'b0};
        last_lat = -1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data_i = fr[i];
            if (glitch) begin
                cyc(12); ps2_clk_i = 1'b0; cyc(3); ps2_clk_i = 1'b1; cyc(HALF - 15);
            end else begin
                cyc(HALF);
            end
            ps2_clk_i = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                cyc(1);
                if (last_lat < 0 && valid_o === 1'b1) last_lat = k;
            end
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        cyc(HALF);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       par_flip;
        logic       stop;
        int         exp_rx;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h33,       1'b0, 1'b1, 1, 0, 0};
        vecs[1] = '{8'h29,       1'b1, 1'b1, 0, 1, 0};
        vecs[2] = '{8'h12,       1'b0, 1'b0, 0, 0, 1};
        vecs[3] = '{8'h5A,       1'b0, 1'b1, 1, 0, 0};
        vecs[4] = '{KEY_RELEASE, 1'b0, 1'b1, 1, 0, 0};
        vecs[5] = '{8'h00,       1'b0, 1'b1, 1, 0, 0};
        vecs[6] = '{8'hFF,       1'b1, 1'b0, 0, 0, 1};

        reset_ni = 1'b0; cyc(4); reset_ni = 1'b1; cyc(1);
        check("reset_valid", 32'(valid_o), 0);
        check("reset_data", 32'(data_o), 0);
        check("reset_perr", 32'(parity_err_o), 0);
        check("reset_ferr", 32'(frame_err_o), 0);
        check("reset_ovf", 32'(overflow_o), 0);

        for (int v = 0; v < 7; v++) begin
            snap();
            send_frame(vecs[v].code, vecs[v].par_flip, vecs[v].stop, 11, 1'b0);
            cyc(4);
            check($sformatf("vec%0d_rx", v), 32'(n_rx - b_rx), 32'(vecs[v].exp_rx));
            check($sformatf("vec%0d_perr", v), 32'(n_perr - b_perr), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d_ferr", v), 32'(n_ferr - b_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovf", v), 32'(n_ovf - b_ovf), 0);
            if (vecs[v].exp_rx == 1) begin
                check($sformatf("vec%0d_data", v), 32'(rx_log[b_rx[7:0]]), 32'(vecs[v].code));
                check($sformatf("vec%0d_latency", v), 32'(last_lat), 32'(FL + 3));
            end
        end

        // Three frames with the consumer stalled.
        ready_i = 1'b0;
        snap();
        send_frame(8'h1D, 1'b0, 1'b1, 11, 1'b0);
        send_frame(KEY_RELEASE, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b1, 11, 1'b0);
        check("stall_valid", 32'(valid_o), 1);
        check("stall_head", 32'(data_o), 32'h1D);
        check("stall_ovf", 32'(n_ovf - b_ovf), 32'(EXP_OVF));
        ready_i = 1'b1;
        cyc(6);
        check("stall_drained", 32'(n_rx - b_rx), 32'(EXP_HELD));
        check("stall_pop0", 32'(rx_log[b_rx[7:0]]), 32'h1D);
`ifdef PS2_RX_FIFO_EN
        check("stall_pop1", 32'(rx_log[8'(b_rx + 1)]), 32'(KEY_RELEASE));
        check("stall_pop2", 32'(rx_log[8'(b_rx + 2)]), 32'h1D);
`endif
        check("stall_empty", 32'(valid_o), 0);

        // Partial frame then a silent clock: timeout aborts it.
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        cyc(TMO + 10);
        check("tmo_ferr", 32'(n_ferr - b_ferr), 1);
        check("tmo_rx", 32'(n_rx - b_rx), 0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
        cyc(4);
        check("tmo_next_rx", 32'(n_rx - b_rx), 1);
        check("tmo_next_data", 32'(rx_log[b_rx[7:0]]), 32'h5A);

        // Short clock glitches while idle and during every bit.
        snap();
        ps2_clk_i = 1'b0; cyc(3); ps2_clk_i = 1'b1; cyc(20);
        send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b1);
        cyc(4);
        check("glitch_rx", 32'(n_rx - b_rx), 1);
        check("glitch_data", 32'(rx_log[b_rx[7:0]]), 32'h4B);
        check("glitch_perr", 32'(n_perr - b_perr), 0);
        check("glitch_ferr", 32'(n_ferr - b_ferr), 0);

        // Reset in the middle of a frame while a byte is held.
        ready_i = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        check("pre_reset_valid", 32'(valid_o), 1);
        send_frame(8'h77, 1'b0, 1'b1, 6, 1'b0);
        reset_ni = 1'b0; cyc(1); reset_ni = 1'b1;
        check("mid_reset_valid", 32'(valid_o), 0);
        check("mid_reset_data", 32'(data_o), 0);
        ready_i = 1'b1;
        snap();
        send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0);
        cyc(4);
        check("post_reset_rx", 32'(n_rx - b_rx), 1);
        check("post_reset_data", 32'(rx_log[b_rx[7:0]]), 32'h44);
        check("post_reset_ferr", 32'(n_ferr - b_ferr), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1);
    end

endmodule
